instr_stream_loader: RTL and testbench

//  Inverse of the opcode decoder: accepts instruction fields over a valid/ready stream,

---
 rtl/instr_stream_loader_pkg.sv | 38 +++
 rtl/instr_stream_loader_if.sv | 27 ++
 rtl/instr_stream_loader_encode.sv | 40 ++++
 rtl/instr_stream_loader.sv | 139 +++++++++++++
 tb/tb_instr_stream_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_stream_loader_pkg.sv
// Shared types for the instruction stream loader: opcode values, format codes,
// field bundle layout and FSM state encoding.
package instr_stream_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LB    = 6'd32;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

endpackage

// File: rtl/instr_stream_loader_if.sv
// Valid/ready field-bundle stream feeding the loader; master is the producer.
interface instr_stream_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_stream_loader_encode.sv
// Combinational packer: turns a field bundle into a 32-bit MIPS word and flags
// whether the format/opcode pair is one the control unit executes.
module instr_stream_loader_encode
    import instr_stream_loader_pkg::*;
(
    input  fields_t     fields,
    output logic [31:0] word,
    output logic        legal
);

    logic i_op_ok;

    assign i_op_ok = ((fields.opcode >= OP_BEQ) && (fields.opcode <= OP_LUI)) ||
                     (fields.opcode == OP_LB) || (fields.opcode == OP_LW) ||
                     (fields.opcode == OP_SB) || (fields.opcode == OP_SW);

    always_comb begin
        word  = 32'd0;
        legal = 1'b0;
        case (fields.fmt)
            FMT_R: begin
                word  = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
                legal = (fields.opcode == OP_RTYPE);
            end
            FMT_I: begin
                word  = {fields.opcode, fields.rs, fields.rt, fields.imm};
                legal = i_op_ok;
            end
            FMT_J: begin
                word  = {fields.opcode, fields.target};
                legal = (fields.opcode == OP_J) || (fields.opcode == OP_JAL);
            end
            default: begin
                word  = 32'd0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_stream_loader.sv
// Program loader: accepts field bundles, encodes them and writes legal words
// sequentially into instruction memory, one word per two cycles.
module instr_stream_loader
    import instr_stream_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_stream_loader_if.slave  s_in,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_ovf,
    output logic [ADDR_W:0]       count
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_1  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_1 = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              legal_q, legal_d;
    logic              last_q, last_d;
    logic              ill_q, ill_d;
    logic              ovf_q, ovf_d;

    fields_t     fields;
    logic [31:0] enc_word;
    logic        enc_legal;

    assign fields = '{fmt:    s_in.in_fmt,
                      opcode: s_in.in_opcode,
                      rs:     s_in.in_rs,
                      rt:     s_in.in_rt,
                      rd:     s_in.in_rd,
                      shamt:  s_in.in_shamt,
                      funct:  s_in.in_funct,
                      imm:    s_in.in_imm,
                      target: s_in.in_target};

    instr_stream_loader_encode u_encode (
        .fields (fields),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        count_d        = count_q;
        word_d         = word_q;
        legal_d        = legal_q;
        last_d         = last_q;
        ill_d          = ill_q;
        ovf_d          = ovf_q;
        s_in.in_ready  = 1'b0;
        imem_we        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = BASE;
                    count_d = '0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                // Memory already full: refuse further bundles rather than overwrite.
                if (count_q == DEPTH) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    s_in.in_ready = 1'b1;
                    if (s_in.in_valid) begin
                        word_d  = enc_word;
                        legal_d = enc_legal;
                        last_d  = s_in.in_last;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (legal_q) begin
                    imem_we = 1'b1;
                    addr_d  = addr_q + ADDR_1;
                    if (count_q != DEPTH) begin
                        count_d = count_q + COUNT_1;
                    end
                end else begin
                    ill_d = 1'b1;
                end
                state_d = last_q ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            word_q  <= 32'd0;
            legal_q <= 1'b0;
            last_q  <= 1'b0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            legal_q <= legal_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign imem_addr   = addr_q;
    assign imem_wdata  = word_q;
    assign busy        = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign err_illegal = ill_q;
    assign err_ovf     = ovf_q;
    assign count       = count_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench: a default-size loader plus a 4-word loader for the overflow case,
// with a write-capture memory per instance and hand-computed instruction words.
module tb_instr_stream_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic v_a = 1'b0;
    logic v_b = 1'b0;
    logic sel_b = 1'b0;

    logic [1:0]  f_fmt = 2'd0;
    logic [5:0]  f_op = 6'd0;
    logic [4:0]  f_rs = 5'd0, f_rt = 5'd0, f_rd = 5'd0, f_shamt = 5'd0;
    logic [5:0]  f_funct = 6'd0;
    logic [15:0] f_imm = 16'd0;
    logic [25:0] f_tgt = 26'd0;
    logic        f_last = 1'b0;

    int nvec = 0;
    int nerr = 0;

    instr_stream_loader_if ia ();
    instr_stream_loader_if ib ();

    assign ia.in_valid = v_a;       assign ib.in_valid = v_b;
    assign ia.in_fmt = f_fmt;       assign ib.in_fmt = f_fmt;
    assign ia.in_opcode = f_op;     assign ib.in_opcode = f_op;
    assign ia.in_rs = f_rs;         assign ib.in_rs = f_rs;
    assign ia.in_rt = f_rt;         assign ib.in_rt = f_rt;
    assign ia.in_rd = f_rd;         assign ib.in_rd = f_rd;
    assign ia.in_shamt = f_shamt;   assign ib.in_shamt = f_shamt;
    assign ia.in_funct = f_funct;   assign ib.in_funct = f_funct;
    assign ia.in_imm = f_imm;       assign ib.in_imm = f_imm;
    assign ia.in_target = f_tgt;    assign ib.in_target = f_tgt;
    assign ia.in_last = f_last;     assign ib.in_last = f_last;

    logic        we_a, busy_a, done_a, ill_a, ovf_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  count_a;
    logic        we_b, busy_b, done_b, ill_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    instr_stream_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .s_in(ia),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err_illegal(ill_a), .err_ovf(ovf_a),
        .count(count_a)
    );

    instr_stream_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .s_in(ib),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err_illegal(ill_b), .err_ovf(ovf_b),
        .count(count_b)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [4];
    int wcnt_a = 0;
    int wcnt_b = 0;

    always @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= wdata_a;
            wcnt_a <= wcnt_a + 1;
        end
        if (we_b) begin
            mem_b[addr_b] <= wdata_b;
            wcnt_b <= wcnt_b + 1;
        end
    end

    logic       rdy, we_sel;
    logic [7:0] addr_sel;
    assign rdy      = sel_b ? ib.in_ready : ia.in_ready;
    assign we_sel   = sel_b ? we_b : we_a;
    assign addr_sel = sel_b ? {6'd0, addr_b} : addr_a;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic b);
        @(negedge clk);
        sel_b = b;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Returns at the negedge of the WRITE cycle that follows the handshake.
    task automatic send(input logic [1:0] fmt, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input logic exp_we, input logic [7:0] exp_addr, input string tag);
        int n;
        f_fmt = fmt; f_op = op; f_rs = rs; f_rt = rt; f_rd = rd; f_shamt = shamt;
        f_funct = funct; f_imm = imm; f_tgt = tgt; f_last = last;
        if (sel_b) v_b = 1'b1; else v_a = 1'b1;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            check_vec({tag, "_hs_timeout"}, 64'd0, 64'd1);
            v_a = 1'b0;
            v_b = 1'b0;
            return;
        end
        @(negedge clk);
        v_a = 1'b0;
        v_b = 1'b0;
        check_vec({tag, "_we"}, 64'(we_sel), 64'(exp_we));
        if (exp_we) check_vec({tag, "_addr"}, 64'(addr_sel), 64'(exp_addr));
    endtask

    task automatic send_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [15:0] imm, input logic last,
                          input logic exp_we, input logic [7:0] exp_addr, input string tag);
        send(2'd1, op, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0, last, exp_we, exp_addr, tag);
    endtask

    int snap;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_vec("rst_ready", 64'(ia.in_ready), 64'd0);
        check_vec("rst_we", 64'(we_a), 64'd0);
        check_vec("rst_busy", 64'(busy_a), 64'd0);
        check_vec("rst_done", 64'(done_a), 64'd0);
        check_vec("rst_err", 64'({ill_a, ovf_a}), 64'd0);
        check_vec("rst_count", 64'(count_a), 64'd0);
        check_vec("rst_addr", 64'(addr_a), 64'd0);
        check_vec("rst_wdata", 64'(wdata_a), 64'd0);
        rst_n = 1'b1;

        // ori / lw / sw program
        pulse_start(1'b0);
        check_vec("t1_busy", 64'(busy_a), 64'd1);
        snap = wcnt_a;
        send_i(6'd13, 5'd0, 5'd1, 16'd5, 1'b0, 1'b1, 8'd0, "t1_ori");
        check_vec("t1_wdata0", 64'(wdata_a), 64'h34010005);
        send_i(6'd35, 5'd1, 5'd2, 16'd0, 1'b0, 1'b1, 8'd1, "t1_lw");
        send_i(6'd43, 5'd1, 5'd2, 16'd4, 1'b1, 1'b1, 8'd2, "t1_sw");
        @(negedge clk);
        check_vec("t1_done", 64'(done_a), 64'd1);
        check_vec("t1_busy_off", 64'(busy_a), 64'd0);
        check_vec("t1_count", 64'(count_a), 64'd3);
        check_vec("t1_nwrites", 64'(wcnt_a - snap), 64'd3);
        check_vec("t1_mem0", 64'(mem_a[0]), 64'h34010005);
        check_vec("t1_mem1", 64'(mem_a[1]), 64'h8C220000);
        check_vec("t1_mem2", 64'(mem_a[2]), 64'hAC220004);

        // R and J formats
        pulse_start(1'b0);
        check_vec("t2_count_clr", 64'(count_a), 64'd0);
        send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 1'b1, 8'd0, "t2_add");
        send(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h100, 1'b1, 1'b1, 8'd1, "t2_j");
        @(negedge clk);
        check_vec("t2_mem0", 64'(mem_a[0]), 64'h00221820);
        check_vec("t2_mem1", 64'(mem_a[1]), 64'h08000100);
        check_vec("t2_done", 64'(done_a), 64'd1);

        // illegal bundles between legal ones
        pulse_start(1'b0);
        snap = wcnt_a;
        send_i(6'd13, 5'd0, 5'd1, 16'd5, 1'b0, 1'b1, 8'd0, "t3_ori");
        check_vec("t3_ill_clear", 64'(ill_a), 64'd0);
        send_i(6'd1, 5'd0, 5'd1, 16'd9, 1'b0, 1'b0, 8'd1, "t3_op1");
        send(2'd3, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 1'b0, 8'd1, "t3_fmt3");
        check_vec("t3_addr_held", 64'(addr_a), 64'd1);
        send_i(6'd35, 5'd1, 5'd2, 16'd0, 1'b1, 1'b1, 8'd1, "t3_lw");
        @(negedge clk);
        check_vec("t3_err_illegal", 64'(ill_a), 64'd1);
        check_vec("t3_count", 64'(count_a), 64'd2);
        check_vec("t3_nwrites", 64'(wcnt_a - snap), 64'd2);
        check_vec("t3_mem1", 64'(mem_a[1]), 64'h8C220000);

        // overflow on the 4-word instance
        pulse_start(1'b1);
        snap = wcnt_b;
        send_i(6'd13, 5'd0, 5'd1, 16'd1, 1'b0, 1'b1, 8'd0, "t4_w0");
        send_i(6'd13, 5'd0, 5'd1, 16'd2, 1'b0, 1'b1, 8'd1, "t4_w1");
        send_i(6'd13, 5'd0, 5'd1, 16'd3, 1'b0, 1'b1, 8'd2, "t4_w2");
        send_i(6'd13, 5'd0, 5'd1, 16'd4, 1'b0, 1'b1, 8'd3, "t4_w3");
        f_imm = 16'd5;
        v_b = 1'b1;
        @(negedge clk);
        check_vec("t4_ready_low", 64'(ib.in_ready), 64'd0);
        repeat (3) @(negedge clk);
        v_b = 1'b0;
        check_vec("t4_err_ovf", 64'(ovf_b), 64'd1);
        check_vec("t4_done", 64'(done_b), 64'd1);
        check_vec("t4_count", 64'(count_b), 64'd4);
        check_vec("t4_nwrites", 64'(wcnt_b - snap), 64'd4);
        check_vec("t4_mem0", 64'(mem_b[0]), 64'h34010001);
        check_vec("t4_mem3", 64'(mem_b[3]), 64'h34010004);

        // reset asserted during WRITE
        pulse_start(1'b0);
        send_i(6'd13, 5'd0, 5'd1, 16'd5, 1'b0, 1'b1, 8'd0, "t5_w0");
        send_i(6'd35, 5'd1, 5'd2, 16'd0, 1'b0, 1'b1, 8'd1, "t5_w1");
        rst_n = 1'b0;
        @(negedge clk);
        snap = wcnt_a;
        check_vec("t5_busy", 64'(busy_a), 64'd0);
        check_vec("t5_count", 64'(count_a), 64'd0);
        check_vec("t5_addr", 64'(addr_a), 64'd0);
        check_vec("t5_wdata", 64'(wdata_a), 64'd0);
        rst_n = 1'b1;
        v_a = 1'b1;
        repeat (3) @(negedge clk);
        v_a = 1'b0;
        check_vec("t5_no_we", 64'(wcnt_a - snap), 64'd0);
        check_vec("t5_idle", 64'(busy_a), 64'd0);
        pulse_start(1'b0);
        send_i(6'd43, 5'd1, 5'd2, 16'd4, 1'b1, 1'b1, 8'd0, "t5_resume");
        @(negedge clk);
        check_vec("t5_mem0", 64'(mem_a[0]), 64'hAC220004);
        check_vec("t5_count1", 64'(count_a), 64'd1);

        // start held high while loading
        pulse_start(1'b0);
        snap = wcnt_a;
        start_a = 1'b1;
        send_i(6'd13, 5'd0, 5'd1, 16'd7, 1'b0, 1'b1, 8'd0, "t6_w0");
        @(negedge clk);
        start_a = 1'b0;
        check_vec("t6_count", 64'(count_a), 64'd1);
        check_vec("t6_single_we", 64'(wcnt_a - snap), 64'd1);
        send_i(6'd35, 5'd1, 5'd2, 16'd0, 1'b1, 1'b1, 8'd1, "t6_w1");
        @(negedge clk);
        check_vec("t6_mem0", 64'(mem_a[0]), 64'h34010007);
        check_vec("t6_done", 64'(done_a), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
